// File: rtl/shift_pkg.sv
// Shared encodings for the iterative shift unit.
// Rotate decode is controlled by SEQ_SHIFT_ROTATE_EN.
package shift_pkg;

  localparam logic [2:0] OP_SLL  = 3'b000;
  localparam logic [2:0] OP_PASS = 3'b001;
  localparam logic [2:0] OP_SRL  = 3'b010;
  localparam logic [2:0] OP_SRA  = 3'b011;
  localparam logic [2:0] OP_ROL  = 3'b100;
  localparam logic [2:0] OP_ROR  = 3'b101;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  // True when the op consumes the shift amount; everything else behaves as PASS.
  function automatic logic op_shifts(input logic [2:0] op);
    logic r;
    case (op)
      OP_SLL, OP_SRL, OP_SRA: r = 1'b1;
`ifdef SEQ_SHIFT_ROTATE_EN
      OP_ROL, OP_ROR:         r = 1'b1;
`endif
      default:                r = 1'b0;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/shift_step.sv
// One combinational step of 0..STEP bits for the latched op.
// Rotates exist only when SEQ_SHIFT_ROTATE_EN is defined.
module shift_step
  import shift_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int STEP  = 1
) (
  input  logic [2:0]               op,
  input  logic [$clog2(WIDTH)-1:0] k,
  input  logic [WIDTH-1:0]         din,
  output logic [WIDTH-1:0]         dout
);

`ifdef SEQ_SHIFT_ROTATE_EN
  logic [2*WIDTH-1:0] dd;
  assign dd = {din, din};
`endif

  // Only amounts 0..STEP are decoded, so this stays a STEP+1 way mux.
  always_comb begin
    dout = din;
    for (int i = 0; i <= STEP; i++) begin
      if (int'(k) == i) begin
        case (op)
          OP_SLL:  dout = din << i;
          OP_SRL:  dout = din >> i;
          OP_SRA:  dout = $signed(din) >>> i;
`ifdef SEQ_SHIFT_ROTATE_EN
          OP_ROL:  dout = dd[2*WIDTH-1-i -: WIDTH];
          OP_ROR:  dout = dd[WIDTH-1+i -: WIDTH];
`endif
          default: dout = din;
        endcase
      end
    end
  end

endmodule

// File: rtl/seq_shift_unit.sv
// Iterative shift unit with start/busy/done handshake, up to STEP bits per clock.
// Define SEQ_SHIFT_ROTATE_EN to enable ROL/ROR; otherwise those ops act as PASS.
//
// state   | meaning
// IDLE    | waiting for start, dataout holds last result
// RUN     | stepping dataout, rem bits still to shift
// DONE    | one-cycle result-valid pulse; start here chains the next op
module seq_shift_unit
  import shift_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int STEP  = 1
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     start,
  input  logic [2:0]               op,
  input  logic [$clog2(WIDTH)-1:0] s,
  input  logic [WIDTH-1:0]         datain,
  output logic                     busy,
  output logic                     done,
  output logic [WIDTH-1:0]         dataout
);

  localparam int SW = $clog2(WIDTH);
  // rem never exceeds WIDTH-1, so clipping STEP there keeps min() exact.
  localparam int STEP_CLIP = (STEP < WIDTH) ? STEP : WIDTH - 1;
  localparam logic [SW-1:0] STEP_K = SW'(STEP_CLIP);

  state_t          state, state_nxt;
  logic            accept;
  logic [SW-1:0]   rem, k;
  logic [2:0]      op_q;
  logic [WIDTH-1:0] step_out;

  always_comb k = (rem > STEP_K) ? STEP_K : rem;

  shift_step #(.WIDTH(WIDTH), .STEP(STEP)) u_step (
    .op   (op_q),
    .k    (k),
    .din  (dataout),
    .dout (step_out)
  );

  always_comb begin
    state_nxt = state;
    accept    = 1'b0;
    case (state)
      ST_IDLE: begin
        if (start) begin
          accept    = 1'b1;
          state_nxt = ST_RUN;
        end
      end
      ST_RUN: begin
        if (rem == '0) state_nxt = ST_DONE;
      end
      ST_DONE: begin
        accept    = start;
        state_nxt = start ? ST_RUN : ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= ST_IDLE;
    else       state <= state_nxt;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rem     <= '0;
      op_q    <= OP_PASS;
      dataout <= '0;
    end else if (accept) begin
      dataout <= datain;
      op_q    <= op;
      rem     <= op_shifts(op) ? s : '0;
    end else if (state == ST_RUN && rem != '0) begin
      dataout <= step_out;
      rem     <= rem - k;
    end
  end

  assign busy = (state == ST_RUN);
  assign done = (state == ST_DONE);

endmodule

// File: tb/tb_seq_shift_unit.sv
// Randomized bench for seq_shift_unit: STEP=1 and STEP=8 instances checked against a reference model.
// Honours SEQ_SHIFT_ROTATE_EN the same way the design does.
module tb_seq_shift_unit;

  localparam int W = 32;

  logic         clk = 1'b0;
  logic         reset;
  logic         start1, start8;
  logic [2:0]   op;
  logic [4:0]   s;
  logic [W-1:0] datain;
  logic         busy1, done1, busy8, done8;
  logic [W-1:0] dout1, dout8;

  int n_checks = 0;
  int n_errors = 0;
  bit rot_en;

  always #5 clk = ~clk;

  seq_shift_unit #(.WIDTH(W), .STEP(1)) u_dut1 (
    .clk(clk), .reset(reset), .start(start1), .op(op), .s(s), .datain(datain),
    .busy(busy1), .done(done1), .dataout(dout1)
  );

  seq_shift_unit #(.WIDTH(W), .STEP(8)) u_dut8 (
    .clk(clk), .reset(reset), .start(start8), .op(op), .s(s), .datain(datain),
    .busy(busy8), .done(done8), .dataout(dout8)
  );

  task automatic chk(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  function automatic logic [W-1:0] ref_result(input logic [2:0] o, input int sh, input logic [W-1:0] d);
    logic [2*W-1:0] dd;
    dd = {d, d};
    case (o)
      3'd0: return d << sh;
      3'd2: return d >> sh;
      3'd3: return $signed(d) >>> sh;
      3'd4: if (rot_en) begin dd = dd << sh; return dd[2*W-1:W]; end else return d;
      3'd5: if (rot_en) begin dd = dd >> sh; return dd[W-1:0];   end else return d;
      default: return d;
    endcase
  endfunction

  function automatic int ref_latency(input logic [2:0] o, input int sh, input int step);
    bit shifts;
    shifts = (o == 3'd0) || (o == 3'd2) || (o == 3'd3) || (rot_en && (o == 3'd4 || o == 3'd5));
    return shifts ? (sh + step - 1) / step + 1 : 1;
  endfunction

  task automatic run_op(input logic [2:0] o, input int sh, input logic [W-1:0] d, input bit poke);
    logic [W-1:0] exp, r1, r8;
    int l1, l8, lmin, lmax, at1, at8, nb1, nb8, nd1, nd8;
    exp  = ref_result(o, sh, d);
    l1   = ref_latency(o, sh, 1);
    l8   = ref_latency(o, sh, 8);
    lmin = (l1 < l8) ? l1 : l8;
    lmax = (l1 > l8) ? l1 : l8;
    at1 = -1; at8 = -1; nb1 = 0; nb8 = 0; nd1 = 0; nd8 = 0;
    r1 = '0; r8 = '0;
    @(negedge clk);
    op = o; s = 5'(sh); datain = d; start1 = 1'b1; start8 = 1'b1;
    @(posedge clk);
    for (int j = 0; j <= lmax + 1; j++) begin
      @(negedge clk);
      if (busy1) nb1++;
      if (busy8) nb8++;
      if (done1) begin nd1++; if (at1 < 0) begin at1 = j; r1 = dout1; end end
      if (done8) begin nd8++; if (at8 < 0) begin at8 = j; r8 = dout8; end end
      // stray starts only while both units are in RUN, and scrambled inputs, must be ignored
      start1 = poke && (j < lmin) && ($urandom_range(0, 1) == 1);
      start8 = start1;
      op = 3'($urandom); s = 5'($urandom); datain = $urandom;
    end
    start1 = 1'b0; start8 = 1'b0;
    chk("latency_step1", W'(at1), W'(l1));
    chk("latency_step8", W'(at8), W'(l8));
    chk("busy_cycles_step1", W'(nb1), W'(l1));
    chk("busy_cycles_step8", W'(nb8), W'(l8));
    chk("done_pulses_step1", W'(nd1), 32'd1);
    chk("done_pulses_step8", W'(nd8), 32'd1);
    chk("result_step1", r1, exp);
    chk("result_step8", r8, exp);
  endtask

  task automatic reset_mid_run();
    int nd;
    nd = 0;
    @(negedge clk);
    op = 3'd0; s = 5'd20; datain = $urandom; start1 = 1'b1; start8 = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start1 = 1'b0; start8 = 1'b0;
    repeat (5) @(negedge clk);
    #2 reset = 1'b1;
    #1;
    chk("rst_busy", W'(busy1), 32'd0);
    chk("rst_done", W'(done1), 32'd0);
    chk("rst_dataout", dout1, 32'd0);
    chk("rst_dataout_step8", dout8, 32'd0);
    @(negedge clk);
    reset = 1'b0;
    for (int j = 0; j < 25; j++) begin
      @(negedge clk);
      if (done1 || busy1) nd++;
    end
    chk("rst_no_done_after", W'(nd), 32'd0);
  endtask

  task automatic back_to_back();
    int ja, jb, nd;
    logic [W-1:0] ra, rb;
    ja = -1; jb = -1; nd = 0; ra = '0; rb = '0;
    @(negedge clk);
    op = 3'd2; s = 5'd2; datain = 32'h0000_00F0; start1 = 1'b1;
    @(posedge clk);
    for (int j = 0; j <= 10; j++) begin
      @(negedge clk);
      if (done1) begin
        nd++;
        if (ja < 0) begin ja = j; ra = dout1; end
        else if (jb < 0) begin jb = j; rb = dout1; end
      end
      if (j == 0) begin op = 3'd0; s = 5'd1; datain = 32'h0000_0003; end
      if (ja >= 0 && j == ja + 1) begin
        chk("b2b_reaccepted", W'(busy1), 32'd1);
        start1 = 1'b0;
      end
    end
    start1 = 1'b0;
    chk("b2b_first_latency", W'(ja), 32'd3);
    chk("b2b_first_result", ra, 32'h0000_003C);
    chk("b2b_second_latency", W'(jb), 32'd6);
    chk("b2b_second_result", rb, 32'h0000_0006);
    chk("b2b_done_pulses", W'(nd), 32'd2);
  endtask

  initial begin
`ifdef SEQ_SHIFT_ROTATE_EN
    rot_en = 1'b1;
`else
    rot_en = 1'b0;
`endif
    reset = 1'b1; start1 = 1'b0; start8 = 1'b0;
    op = 3'd0; s = 5'd0; datain = '0;
    repeat (2) @(negedge clk);
    chk("reset_busy", W'(busy1), 32'd0);
    chk("reset_done", W'(done1), 32'd0);
    chk("reset_dataout", dout1, 32'd0);
    chk("reset_busy_step8", W'(busy8), 32'd0);
    reset = 1'b0;

    run_op(3'd3, 4,  32'h8000_00F0, 1'b0);
    run_op(3'd2, 4,  32'h8000_00F0, 1'b0);
    run_op(3'd0, 31, 32'h0000_0001, 1'b1);
    run_op(3'd1, 17, 32'h1234_5678, 1'b1);
    run_op(3'd0, 0,  32'h1234_5678, 1'b1);
    run_op(3'd5, 8,  32'h1122_3344, 1'b1);
    run_op(3'd4, 4,  32'h1122_3344, 1'b1);
    run_op(3'd7, 9,  32'hDEAD_BEEF, 1'b0);
    run_op(3'd3, 31, 32'h7FFF_FFFF, 1'b0);

    for (int n = 0; n < 40; n++)
      run_op(3'($urandom), int'($urandom_range(0, 31)), $urandom, 1'($urandom));

    reset_mid_run();
    run_op(3'd2, 13, 32'hCAFE_F00D, 1'b1);
    back_to_back();
    run_op(3'd3, 7, 32'h9000_0001, 1'b1);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
